line_fifo_ctrl: RTL and testbench

//  Sequences two external sync_fifo line buffers (FIFO0, FIFO1) that form the 3-row delay line of the
//  3x3 window generator in front of the bilateral filter core. Counts pixels and rows per frame,

---
 rtl/line_fifo_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_line_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// line_fifo_ctrl
//   Sequencer for the two external show-ahead line FIFOs that form the 3-row
//   delay line of the 3x3 window generator. Counts pixels/rows per frame,
//   drives the FIFO write/read strobes, flags valid window centres and drains
//   both FIFOs at the end of the frame. Pixel data never passes through here:
//   FIFO0.din = pixel, FIFO1.din = FIFO0.dout.
//
//   Optional feature macro: LINE_FIFO_CTRL_ERR_CHECK_EN
//     defined     : err is a sticky protocol-error flag
//     not defined : err tied low, full/empty inputs unused
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   frame_start          one-cycle pulse, starts a frame from IDLE
//   pix_vld              input pixel valid
//   fifo{0,1}_full/empty FIFO status (error checking only)
//   fifo{0,1}_wr_en/rd_en combinational FIFO strobes
//   win_vld              registered, window centred at (win_row, win_col) ready
//   win_row, win_col     window centre coordinates
//   busy                 controller not in IDLE
//   frame_done           one-cycle pulse once the drain has finished
//   err                  sticky protocol error
// -----------------------------------------------------------------------------
module line_fifo_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_vld,
  input  logic             fifo0_full,
  input  logic             fifo0_empty,
  input  logic             fifo1_full,
  input  logic             fifo1_empty,
  output logic             fifo0_wr_en,
  output logic             fifo0_rd_en,
  output logic             fifo1_wr_en,
  output logic             fifo1_rd_en,
  output logic             win_vld,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  // state | meaning
  // IDLE  | waiting for frame_start, no strobes
  // FILL0 | row 0: write FIFO0 only
  // FILL1 | row 1: FIFO0 write+read, FIFO1 write
  // RUN   | rows 2..IMG_H-1: all strobes follow pix_vld, windows produced
  // DRAIN | IMG_W cycles of reads on both FIFOs, pix_vld ignored
  // DONE  | frame_done pulse, back to IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL0 = 3'd1,
    FILL1 = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] drain_cnt;

  logic in_pix;
  logic accept;
  logic end_of_row;

  assign in_pix     = (state == FILL0) || (state == FILL1) || (state == RUN);
  assign accept     = pix_vld && in_pix;
  assign end_of_row = accept && (col == COL_LAST);
  assign busy       = (state != IDLE);

  // Zero-latency strobes straight from pix_vld and the current state.
  always_comb begin
    fifo0_wr_en = 1'b0;
    fifo0_rd_en = 1'b0;
    fifo1_wr_en = 1'b0;
    fifo1_rd_en = 1'b0;
    case (state)
      FILL0: begin
        fifo0_wr_en = pix_vld;
      end
      FILL1: begin
        fifo0_wr_en = pix_vld;
        fifo0_rd_en = pix_vld;
        fifo1_wr_en = pix_vld;
      end
      RUN: begin
        fifo0_wr_en = pix_vld;
        fifo0_rd_en = pix_vld;
        fifo1_wr_en = pix_vld;
        fifo1_rd_en = pix_vld;
      end
      DRAIN: begin
        fifo0_rd_en = 1'b1;
        fifo1_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      drain_cnt  <= '0;
      win_vld    <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_vld    <= 1'b0;
      frame_done <= 1'b0;

      // Row wraps back to 0 after the last pixel so the next frame starts clean.
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      // Pixel (row, col) completes the window centred one row up, one column left.
      if ((state == RUN) && accept && (col >= COL_TWO)) begin
        win_vld <= 1'b1;
        win_row <= row - ROW_W'(1);
        win_col <= col - COL_W'(1);
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= FILL0;
            col   <= '0;
            row   <= '0;
          end
        end
        FILL0: begin
          if (end_of_row) state <= FILL1;
        end
        FILL1: begin
          if (end_of_row) state <= RUN;
        end
        RUN: begin
          if (end_of_row && (row == ROW_LAST)) begin
            state     <= DRAIN;
            drain_cnt <= COL_LAST;
          end
        end
        DRAIN: begin
          // Down-counter loaded with IMG_W-1: terminal count gives IMG_W cycles.
          if (drain_cnt == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - COL_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LINE_FIFO_CTRL_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (fifo0_wr_en && fifo0_full)  ||
                   (fifo1_wr_en && fifo1_full)  ||
                   (fifo0_rd_en && fifo0_empty) ||
                   (fifo1_rd_en && fifo1_empty) ||
                   (frame_start && busy)        ||
                   (pix_vld && ((state == DRAIN) || (state == DONE)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_fifo_flags;
  assign unused_fifo_flags = ^{fifo0_full, fifo0_empty, fifo1_full, fifo1_empty};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_line_fifo_ctrl.sv
module tb_line_fifo_ctrl;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int COL_W = $clog2(W);
  localparam int ROW_W = $clog2(H);
  localparam int DEPTH = W + 1;
`ifdef LINE_FIFO_CTRL_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // phase: 0 FILL0, 1 FILL1, 2 RUN, 3 DRAIN, 4 DONE, 5 IDLE
  typedef struct {
    int ph;
    bit pv;
    bit w0, r0, w1, r1, bsy;
  } vec_t;

  typedef struct {
    int r;
    int c;
  } win_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             pix_vld = 1'b0;
  logic             fifo0_full = 1'b0, fifo0_empty = 1'b1;
  logic             fifo1_full = 1'b0, fifo1_empty = 1'b1;
  logic             fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en;
  logic             win_vld;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             busy, frame_done, err;

  line_fifo_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_vld(pix_vld),
    .fifo0_full(fifo0_full), .fifo0_empty(fifo0_empty),
    .fifo1_full(fifo1_full), .fifo1_empty(fifo1_empty),
    .fifo0_wr_en(fifo0_wr_en), .fifo0_rd_en(fifo0_rd_en),
    .fifo1_wr_en(fifo1_wr_en), .fifo1_rd_en(fifo1_rd_en),
    .win_vld(win_vld), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[12];
  win_t exp_q[$];
  int   occ0, occ1, n_w0, n_r0, n_w1, n_r1, n_win;
  bit   force_e1;
  bit   exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input int ph, input bit pv);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ph == ph && tbl[i].pv == pv) begin
        chk("fifo0_wr_en", fifo0_wr_en, tbl[i].w0);
        chk("fifo0_rd_en", fifo0_rd_en, tbl[i].r0);
        chk("fifo1_wr_en", fifo1_wr_en, tbl[i].w1);
        chk("fifo1_rd_en", fifo1_rd_en, tbl[i].r1);
        chk("busy",        busy,        tbl[i].bsy);
      end
    end
  endtask

  // Count strobes and track FIFO occupancy as seen by the FIFOs.
  task automatic account();
    n_w0 += int'(fifo0_wr_en);
    n_r0 += int'(fifo0_rd_en);
    n_w1 += int'(fifo1_wr_en);
    n_r1 += int'(fifo1_rd_en);
    occ0 += int'(fifo0_wr_en) - int'(fifo0_rd_en);
    occ1 += int'(fifo1_wr_en) - int'(fifo1_rd_en);
  endtask

  task automatic drive_flags();
    fifo0_empty = (occ0 <= 0);
    fifo0_full  = (occ0 >= DEPTH);
    fifo1_empty = (occ1 <= 0) || force_e1;
    fifo1_full  = (occ1 >= DEPTH);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; pix_vld = 1'b0; force_e1 = 1'b0;
    occ0 = 0; occ1 = 0; exp_err = 1'b0;
    exp_q.delete();
    drive_flags();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_win_vld", win_vld, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    check_vec(5, 1'b0);
    next_cycle();
  endtask

  // Window scoreboard: expected centres queued when the pixel is driven.
  always @(negedge clk) begin
    if (rst_n && win_vld) begin
      n_win++;
      if (exp_q.size() == 0) begin
        chk("win_unexpected", 1, 0);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        chk("win_row", 32'(win_row), 32'(e.r));
        chk("win_col", 32'(win_col), 32'(e.c));
      end
    end
  end

  task automatic run_frame(input int gap, input bit drain_pv, input int abort_k,
                           input int fs_k, input int e1_k);
    int k;
    bit pv;
    bit fs_done;
    n_w0 = 0; n_r0 = 0; n_w1 = 0; n_r1 = 0; n_win = 0;
    fs_done = 1'b0;
    chk("occ0_at_start", 32'(occ0), 0);
    chk("occ1_at_start", 32'(occ1), 0);
    frame_start = 1'b1; pix_vld = 1'b0; drive_flags();
    @(negedge clk);
    check_vec(5, 1'b0);
    next_cycle();
    frame_start = 1'b0;
    k = 0;
    while (k < W * H) begin
      pv = ($urandom_range(99) >= gap);
      if (k == abort_k) begin
        rst_n = 1'b0; pix_vld = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        occ0 = 0; occ1 = 0; exp_err = 1'b0;
        exp_q.delete();
        drive_flags();
        @(negedge clk);
        check_vec(5, 1'b1);
        chk("abort_win_vld", win_vld, 0);
        chk("abort_err", err, 0);
        next_cycle();
        pix_vld = 1'b0;
        return;
      end
      pix_vld     = pv;
      frame_start = (k == fs_k) && !fs_done;
      force_e1    = (k == e1_k);
      if (frame_start) fs_done = 1'b1;
      drive_flags();
      @(negedge clk);
      check_vec((k < W) ? 0 : (k < 2 * W) ? 1 : 2, pv);
      if (ERR_EN && (frame_start || (force_e1 && pv && k >= 2 * W))) exp_err = 1'b1;
      account();
      if (pv) begin
        if (k >= 2 * W && (k % W) >= 2) begin
          win_t e;
          e.r = k / W - 1;
          e.c = k % W - 1;
          exp_q.push_back(e);
        end
        k++;
      end
      next_cycle();
    end
    frame_start = 1'b0; force_e1 = 1'b0;
    for (int d = 0; d < W; d++) begin
      pix_vld = drain_pv;
      drive_flags();
      @(negedge clk);
      check_vec(3, drain_pv);
      chk("frame_done_in_drain", frame_done, 0);
      if (ERR_EN && drain_pv) exp_err = 1'b1;
      account();
      next_cycle();
    end
    pix_vld = drain_pv;
    drive_flags();
    @(negedge clk);
    check_vec(4, drain_pv);
    chk("frame_done", frame_done, 1);
    if (ERR_EN && drain_pv) exp_err = 1'b1;
    next_cycle();
    pix_vld = 1'b0;
    drive_flags();
    chk("cnt_fifo0_wr", 32'(n_w0), 32'(W * H));
    chk("cnt_fifo0_rd", 32'(n_r0), 32'(W * (H - 1) + W));
    chk("cnt_fifo1_wr", 32'(n_w1), 32'(W * (H - 1)));
    chk("cnt_fifo1_rd", 32'(n_r1), 32'(W * (H - 2) + W));
    chk("win_count", 32'(n_win), 32'((H - 2) * (W - 2)));
    chk("win_queue_left", 32'(exp_q.size()), 0);
    chk("occ0_end", 32'(occ0), 0);
    chk("occ1_end", 32'(occ1), 0);
    chk("err", err, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            ph pv  w0 r0 w1 r1 busy
    tbl[0]  = '{0, 1'b0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1'b1, 1, 0, 0, 0, 1};
    tbl[2]  = '{1, 1'b0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1'b1, 1, 1, 1, 0, 1};
    tbl[4]  = '{2, 1'b0, 0, 0, 0, 0, 1};
    tbl[5]  = '{2, 1'b1, 1, 1, 1, 1, 1};
    tbl[6]  = '{3, 1'b0, 0, 1, 0, 1, 1};
    tbl[7]  = '{3, 1'b1, 0, 1, 0, 1, 1};
    tbl[8]  = '{4, 1'b0, 0, 0, 0, 0, 1};
    tbl[9]  = '{4, 1'b1, 0, 0, 0, 0, 1};
    tbl[10] = '{5, 1'b0, 0, 0, 0, 0, 0};
    tbl[11] = '{5, 1'b1, 0, 0, 0, 0, 0};
    n_win = 0;

    do_reset();
    chk("rst_win_row", 32'(win_row), 0);
    chk("rst_win_col", 32'(win_col), 0);

    // pix_vld in IDLE is ignored
    pix_vld = 1'b1;
    @(negedge clk);
    check_vec(5, 1'b1);
    next_cycle();
    pix_vld = 1'b0;

    run_frame(0, 1'b0, -1, -1, -1);           // back-to-back pixels
    next_cycle();
    run_frame(50, 1'b0, -1, -1, -1);          // random gaps
    next_cycle();
    run_frame(0, 1'b0, -1, -1, -1);           // two frames back to back
    run_frame(30, 1'b0, -1, -1, -1);
    next_cycle();
    run_frame(0, 1'b0, 2 * W + 2, -1, -1);    // reset in RUN row 2
    run_frame(0, 1'b0, -1, -1, -1);
    next_cycle();
    run_frame(0, 1'b1, -1, -1, -1);           // pix_vld during DRAIN/DONE
    do_reset();
    run_frame(0, 1'b0, -1, W + 1, -1);        // frame_start during FILL1
    do_reset();
    run_frame(0, 1'b0, -1, -1, 2 * W + 3);    // fifo1_empty forced in RUN
    do_reset();
    run_frame(0, 1'b0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
